// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: sub-cycle numbering,
// fetch FSM states and the two-word opcode decode.
package inst_fetch_pkg;

   // Sub-cycle numbers within one instruction cycle.
   localparam logic [2:0] A1 = 3'd0;
   localparam logic [2:0] A2 = 3'd1;
   localparam logic [2:0] A3 = 3'd2;
   localparam logic [2:0] M1 = 3'd3;
   localparam logic [2:0] M2 = 3'd4;
   localparam logic [2:0] X1 = 3'd5;
   localparam logic [2:0] X2 = 3'd6;
   localparam logic [2:0] X3 = 3'd7;

   typedef enum logic {
      WORD1 = 1'b0,
      WORD2 = 1'b1
   } fetch_state_e;

   // Opcode high nibbles that carry a second instruction word.
   localparam logic [3:0] OPR_JCN = 4'h1;
   localparam logic [3:0] OPR_FIM = 4'h2;  // FIM only when opa[0] is clear
   localparam logic [3:0] OPR_JUN = 4'h4;
   localparam logic [3:0] OPR_JMS = 4'h5;
   localparam logic [3:0] OPR_ISZ = 4'h7;

   function automatic logic is_two_word(input logic [3:0] opr, input logic opa_lsb);
      return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
             (opr == OPR_ISZ) || ((opr == OPR_FIM) && !opa_lsb);
   endfunction

endpackage

// File: rtl/inst_fetch_cycle.sv
// Sub-cycle counter for the fetch unit: steps 0..NUM_CYCLES-1 while not
// halted, and flags the last sub-cycle with sync.
module fetch_cycle_counter #(
   parameter int unsigned NUM_CYCLES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       halt_i,
   output logic [2:0] cycle_o,
   output logic       sync_o
);

   localparam logic [2:0] LAST_CYCLE = 3'(NUM_CYCLES - 1);

   logic [2:0] cycle_q, cycle_d;

   // Advance and wrap unless halted.
   always_comb begin
      cycle_d = cycle_q;
      if (!halt_i) begin
         cycle_d = (cycle_q == LAST_CYCLE) ? '0 : cycle_q + 3'd1;
      end
   end

   // Cycle register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) cycle_q <= '0;
      else       cycle_q <= cycle_d;
   end

   assign cycle_o = cycle_q;
   assign sync_o  = !reset && (cycle_q == LAST_CYCLE);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the PC nibbles in A1-A3, samples the opcode in
// M1/M2 and assembles one- or two-word instructions.
// Macro INST_FETCH_TWO_WORD_EN enables two-word decode and the WORD2 state.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned NUM_CYCLES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       halt,
   input  logic [3:0] pc_word,
   input  logic       pc_enable,
   input  logic [3:0] bus_in,
   output logic [2:0] cycle,
   output logic       sync,
   output logic [3:0] bus_out,
   output logic       bus_oe,
   output logic [3:0] opr,
   output logic [3:0] opa,
   output logic [7:0] operand,
   output logic       two_word,
   output logic       inst_valid
);

   localparam logic [2:0] LAST_CYCLE = 3'(NUM_CYCLES - 1);

   logic [2:0]   cyc;
   logic         at_wrap;
   logic         ends_inst;
   fetch_state_e state_q, state_d;
   logic [3:0]   opr_q, opr_d;
   logic [3:0]   opa_q, opa_d;
`ifdef INST_FETCH_TWO_WORD_EN
   logic [7:0]   operand_q, operand_d;
   logic         two_word_q, two_word_d;
`endif

   fetch_cycle_counter #(.NUM_CYCLES(NUM_CYCLES)) u_cycle (
      .clock   (clock),
      .reset   (reset),
      .halt_i  (halt),
      .cycle_o (cyc),
      .sync_o  (sync)
   );

   assign cycle   = cyc;
   assign at_wrap = (cyc == LAST_CYCLE);

   // Bus drive: PC nibbles during A1-A3, released otherwise.
   always_comb begin
      bus_out = '0;
      bus_oe  = 1'b0;
      case (cyc)
         A1, A2, A3: begin
            bus_out = pc_word;
            bus_oe  = pc_enable && !reset;
         end
         M1, M2, X1, X2, X3: begin
         end
      endcase
   end

   // Next-state and latch updates; everything holds while halted.
   always_comb begin
      state_d = state_q;
      opr_d   = opr_q;
      opa_d   = opa_q;
`ifdef INST_FETCH_TWO_WORD_EN
      operand_d  = operand_q;
      two_word_d = two_word_q;
`endif
      if (!halt) begin
         case (state_q)
            WORD1: begin
               if (cyc == M1) opr_d = bus_in;
               if (cyc == M2) opa_d = bus_in;
`ifdef INST_FETCH_TWO_WORD_EN
               if (cyc == X1) two_word_d = is_two_word(opr_q, opa_q[0]);
               // Use the next value so a 6-clock cycle (X1 == last) branches correctly.
               if (at_wrap && two_word_d) state_d = WORD2;
`endif
            end
            WORD2: begin
`ifdef INST_FETCH_TWO_WORD_EN
               if (cyc == M1) operand_d[7:4] = bus_in;
               if (cyc == M2) operand_d[3:0] = bus_in;
`endif
               if (at_wrap) state_d = WORD1;
            end
         endcase
      end
   end

   // State and latch registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= WORD1;
         opr_q   <= '0;
         opa_q   <= '0;
`ifdef INST_FETCH_TWO_WORD_EN
         operand_q  <= '0;
         two_word_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opr_q   <= opr_d;
         opa_q   <= opa_d;
`ifdef INST_FETCH_TWO_WORD_EN
         operand_q  <= operand_d;
         two_word_q <= two_word_d;
`endif
      end
   end

   // The two_word register only updates at the end of X1, so the decode for
   // the instruction completing in X1 is taken straight from opr/opa.
`ifdef INST_FETCH_TWO_WORD_EN
   assign ends_inst = (state_q == WORD2) || !is_two_word(opr_q, opa_q[0]);
   assign operand   = operand_q;
   assign two_word  = two_word_q;
`else
   assign ends_inst = 1'b1;
   assign operand   = '0;
   assign two_word  = 1'b0;
`endif

   assign opr        = opr_q;
   assign opa        = opa_q;
   assign inst_valid = !reset && !halt && (cyc == X1) && ends_inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, hand sequences
// for two-word, halt and reset corners, then randomized stimulus against an
// instruction-level reference model.
module tb_inst_fetch;

   localparam int N = 8;
`ifdef INST_FETCH_TWO_WORD_EN
   localparam bit TW = 1'b1;
`else
   localparam bit TW = 1'b0;
`endif
   // opr values 1,4,5,7 always take a second word; 2 does when opa is even
   localparam logic [15:0] TW_OPR_SET = 16'b0000_0000_1011_0010;

   logic       clock = 1'b0;
   logic       reset, halt, pc_enable;
   logic [3:0] pc_word, bus_in;
   logic [2:0] cycle;
   logic       sync, bus_oe, two_word, inst_valid;
   logic [3:0] bus_out, opr, opa;
   logic [7:0] operand;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_cycle, m_opr, m_opa, m_operand;
   bit m_word2, m_tw;

   always #5 clock = ~clock;

   inst_fetch #(.NUM_CYCLES(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .halt       (halt),
      .pc_word    (pc_word),
      .pc_enable  (pc_enable),
      .bus_in     (bus_in),
      .cycle      (cycle),
      .sync       (sync),
      .bus_out    (bus_out),
      .bus_oe     (bus_oe),
      .opr        (opr),
      .opa        (opa),
      .operand    (operand),
      .two_word   (two_word),
      .inst_valid (inst_valid)
   );

   typedef struct {
      bit         r;
      bit         h;
      logic [3:0] pw;
      bit         pe;
      logic [3:0] bi;
      int         cyc;
      bit         sy;
      logic [3:0] bo;
      bit         oe;
      bit         iv;
      logic [3:0] opr;
      logic [3:0] opa;
      bit         tw;
   } vec_t;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_two_word(input int o, input int a);
      logic [15:0] set_m;
      set_m = TW_OPR_SET;
      if (!TW) return 1'b0;
      return set_m[o[3:0]] || (o == 2 && (a % 2) == 0);
   endfunction

   task automatic model_step();
      if (reset) begin
         m_cycle = 0; m_word2 = 0; m_opr = 0; m_opa = 0; m_operand = 0; m_tw = 0;
      end else if (!halt) begin
         if (m_cycle == 3) begin
            if (m_word2) m_operand = int'(bus_in) * 16 + m_operand % 16;
            else         m_opr = int'(bus_in);
         end
         if (m_cycle == 4) begin
            if (m_word2) m_operand = (m_operand / 16) * 16 + int'(bus_in);
            else         m_opa = int'(bus_in);
         end
         if (m_cycle == 5 && !m_word2) m_tw = ref_two_word(m_opr, m_opa);
         if (m_cycle == N - 1) m_word2 = !m_word2 && m_tw;
         m_cycle = (m_cycle + 1) % N;
      end
   endtask

   task automatic check_model();
      bit a_phase;
      bit exp_iv;
      a_phase = (m_cycle < 3);
      exp_iv  = !reset && !halt && m_cycle == 5 && (m_word2 || !ref_two_word(m_opr, m_opa));
      chk("cycle",      8'(cycle),      8'(m_cycle));
      chk("sync",       8'(sync),       8'(!reset && m_cycle == N - 1));
      chk("bus_oe",     8'(bus_oe),     8'(!reset && a_phase && pc_enable));
      chk("bus_out",    8'(bus_out),    a_phase ? 8'(pc_word) : 8'h00);
      chk("opr",        8'(opr),        8'(m_opr));
      chk("opa",        8'(opa),        8'(m_opa));
      chk("operand",    operand,        8'(m_operand));
      chk("two_word",   8'(two_word),   8'(m_tw));
      chk("inst_valid", 8'(inst_valid), 8'(exp_iv));
   endtask

   task automatic drive(input bit r, input bit h, input logic [3:0] pw, input bit pe,
                        input logic [3:0] bi);
      @(negedge clock);
      reset = r; halt = h; pc_word = pw; pc_enable = pe; bus_in = bi;
      #1;
   endtask

   task automatic clk();
      @(posedge clock);
      model_step();
   endtask

   task automatic idle_until(input int c);
      int guard;
      guard = 0;
      while (m_cycle != c) begin
         if (guard == 2 * N) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_until: cycle %0d never reached", c);
            return;
         end
         drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'h0);
         check_model();
         clk();
         guard++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      int   cnt;

      reset = 1'b1; halt = 1'b0; pc_word = '0; pc_enable = 1'b0; bus_in = '0;
      drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0); clk();
      drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0); clk();

      //          r  h   pw    pe  bi    cyc sy  bo    oe  iv  opr   opa   tw
      tbl[0] = '{1, 0, 4'h5, 1, 4'h0, 0, 0, 4'h5, 0, 0, 4'h0, 4'h0, 0};
      tbl[1] = '{0, 0, 4'hA, 1, 4'h0, 0, 0, 4'hA, 1, 0, 4'h0, 4'h0, 0};
      tbl[2] = '{0, 0, 4'h3, 1, 4'h0, 1, 0, 4'h3, 1, 0, 4'h0, 4'h0, 0};
      tbl[3] = '{0, 0, 4'h0, 1, 4'h0, 2, 0, 4'h0, 1, 0, 4'h0, 4'h0, 0};
      tbl[4] = '{0, 0, 4'hF, 1, 4'hD, 3, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0};
      tbl[5] = '{0, 0, 4'hF, 1, 4'h5, 4, 0, 4'h0, 0, 0, 4'hD, 4'h0, 0};
      tbl[6] = '{0, 0, 4'hF, 1, 4'h0, 5, 0, 4'h0, 0, 1, 4'hD, 4'h5, 0};
      tbl[7] = '{0, 0, 4'hF, 1, 4'h0, 6, 0, 4'h0, 0, 0, 4'hD, 4'h5, 0};
      tbl[8] = '{0, 0, 4'hF, 1, 4'h0, 7, 1, 4'h0, 0, 0, 4'hD, 4'h5, 0};
      tbl[9] = '{0, 0, 4'hA, 0, 4'h0, 0, 0, 4'hA, 0, 0, 4'hD, 4'h5, 0};

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].r, tbl[i].h, tbl[i].pw, tbl[i].pe, tbl[i].bi);
         chk("tbl_cycle",    8'(cycle),      8'(tbl[i].cyc));
         chk("tbl_sync",     8'(sync),       8'(tbl[i].sy));
         chk("tbl_bus_out",  8'(bus_out),    8'(tbl[i].bo));
         chk("tbl_bus_oe",   8'(bus_oe),     8'(tbl[i].oe));
         chk("tbl_valid",    8'(inst_valid), 8'(tbl[i].iv));
         chk("tbl_opr",      8'(opr),        8'(tbl[i].opr));
         chk("tbl_opa",      8'(opa),        8'(tbl[i].opa));
         chk("tbl_two_word", 8'(two_word),   8'(tbl[i].tw));
         chk("tbl_operand",  operand,        8'h00);
         clk();
      end

      // two-word instruction 0x41 followed by operand 0x2F
      idle_until(3);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h4); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h1); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("tw_first_valid", 8'(inst_valid), TW ? 8'd0 : 8'd1);
      check_model(); clk();
      idle_until(3);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h2); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hF); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("tw_second_valid", 8'(inst_valid), 8'd1);
      chk("tw_opr",          8'(opr),        TW ? 8'h4 : 8'h2);
      chk("tw_opa",          8'(opa),        TW ? 8'h1 : 8'hF);
      chk("tw_operand",      operand,        TW ? 8'h2F : 8'h00);
      check_model(); clk();

      // halt for 5 clocks at M1, then again at X1
      idle_until(3);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 4'h0, 1'b1, 4'h9);
         chk("halt_cycle", 8'(cycle), 8'd3);
         chk("halt_opr",   8'(opr),   TW ? 8'h4 : 8'h2);
         chk("halt_opa",   8'(opa),   TW ? 8'h1 : 8'hF);
         check_model(); clk();
      end
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h6); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h8); check_model(); clk();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
         chk("halt_x1_valid", 8'(inst_valid), 8'd0);
         chk("halt_x1_cycle", 8'(cycle),      8'd5);
         check_model(); clk();
      end
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
         if (i == 0) begin
            chk("halt_rel_opr", 8'(opr), 8'h6);
            chk("halt_rel_opa", 8'(opa), 8'h8);
         end
         if (inst_valid === 1'b1) cnt++;
         check_model(); clk();
      end
      chk("halt_valid_once", 8'(cnt), 8'd1);

      // reset in the middle of a second word
      idle_until(3);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h4); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h1); check_model(); clk();
      idle_until(3);
      drive(1'b1, 1'b0, 4'hC, 1'b1, 4'h2);
      chk("rst_w2_sync", 8'(sync),   8'd0);
      chk("rst_w2_oe",   8'(bus_oe), 8'd0);
      check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("rst_w2_cycle",    8'(cycle),    8'd0);
      chk("rst_w2_operand",  operand,      8'h00);
      chk("rst_w2_opr",      8'(opr),      8'h0);
      chk("rst_w2_two_word", 8'(two_word), 8'd0);
      check_model(); clk();
      idle_until(3);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h4); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h1); check_model(); clk();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("rst_after_valid", 8'(inst_valid), TW ? 8'd0 : 8'd1);
      check_model(); clk();

      // reset gating of sync and bus_oe
      idle_until(7);
      drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("rst_sync_gate", 8'(sync), 8'd0);
      check_model(); clk();
      idle_until(1);
      drive(1'b1, 1'b0, 4'h7, 1'b1, 4'h0);
      chk("rst_oe_gate", 8'(bus_oe), 8'd0);
      check_model(); clk();

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) == 0),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)));
         check_model();
         clk();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter NUM_CYCLES, default 8, instruction-cycle period in clocks; legal range 6..8.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 halt  input  1  when high, all internal state holds.
REQ-005 pc_word  input  4  PC nibble from the PC stack.
REQ-006 pc_enable  input  1  PC stack drive-request for pc_word.
REQ-007 bus_in  input  4  external data bus, read side.
REQ-008 cycle  output  3  current sub-cycle, 0..NUM_CYCLES-1; sequences the PC stack.
REQ-009 sync  output  1  high while cycle == NUM_CYCLES-1; marks the next cycle as A1.
REQ-010 bus_out  output  4  external data bus, write side.
REQ-011 bus_oe  output  1  bus_out drive enable.
REQ-012 opr  output  4  latched opcode high nibble.
REQ-013 opa  output  4  latched opcode low nibble.
REQ-014 operand  output  8  second-word byte, {high, low}.
REQ-015 two_word  output  1  current instruction has a second word.
REQ-016 inst_valid  output  1  one-clock pulse; complete instruction on opr/opa/operand.

Function
REQ-017 cycle increments by 1 per clock when halt is low, wrapping NUM_CYCLES-1 -> 0.
REQ-018 Cycles 0,1,2 (A1-A3): bus_out = pc_word, bus_oe = pc_enable (combinational).
REQ-019 Cycle 3 (M1): bus_oe = 0, bus_out = 0; the module samples bus_in at the clock edge ending the cycle.
REQ-020 Cycle 4 (M2): bus_oe = 0, bus_out = 0; the module samples bus_in at the clock edge ending the cycle.
REQ-021 Cycles >= 5: bus_oe = 0, bus_out = 0.
REQ-022 FSM states: WORD1 and WORD2.
  - Reset state: WORD1.
  - Transitions occur only at the clock edge ending cycle NUM_CYCLES-1.
REQ-023 In WORD1, the M1 sample loads opr and the M2 sample loads opa.
REQ-024 Two-word decode, from the opr/opa values present at the cycle-5 edge:
  - opr in {0x1, 0x4, 0x5, 0x7}; or
  - opr == 0x2 with opa[0] == 0.
REQ-025 two_word is registered at the cycle-5 edge in WORD1 and holds until the next WORD1 cycle-5 edge.
REQ-026 WORD1 with two_word = 1 goes to WORD2; WORD2 always returns to WORD1.
REQ-027 In WORD2, the M1 sample loads operand[7:4] and the M2 sample loads operand[3:0]; opr and opa are not updated.
REQ-028 inst_valid timing:
  - Asserted for exactly one clock, during cycle 5.
  - Only in WORD1 when two_word = 0, or in WORD2.
  - Never asserted while halt is high; the pulse is delayed until halt releases.
REQ-029 A one-word instruction leaves operand unchanged.
REQ-030 Simultaneous halt and wrap: halt wins; cycle, state, and latches hold.

Reset
REQ-031 Reset values on the clock edge with reset high, regardless of halt or current cycle:
  - cycle = 0, state = WORD1;
  - opr = opa = 0, operand = 0;
  - two_word = 0, inst_valid = 0.
REQ-032 Reset in the middle of WORD2 discards the partial operand; fetch restarts at A1 of a new WORD1.
REQ-033 While reset is high: sync = 0 and bus_oe = 0.

Configuration
REQ-034 Macro INST_FETCH_TWO_WORD_EN.
  - Defined: two-word decode and the WORD2 state behave as specified above.
  - Undefined: two_word is tied to 0, the WORD2 state is absent, operand is tied to 0, and every instruction is one-word.

Structure
REQ-035 Shared package contents:
  - sub-cycle constants A1..X3;
  - FSM state enum (WORD1, WORD2);
  - two-word opcode constants;
  - the two-word decode function.
REQ-036 One sub-module, fetch_cycle_counter, generates cycle and sync, with halt and reset handling.

Verification
REQ-037 Reset, then 8 clocks with halt = 0 -> cycle steps 0..7 and wraps to 0; sync is high only in cycle 7.
REQ-038 pc_word = 0xA, 0x3, 0x0 in cycles 0-2 with pc_enable = 1 -> bus_out mirrors each value with bus_oe = 1; bus_oe = 0 in cycles 3-7.
REQ-039 bus_in = 0xD in M1, 0x5 in M2 -> opr = 0xD, opa = 0x5, two_word = 0, inst_valid pulses once in cycle 5.
REQ-040 bus_in = 0x4, 0x1, then 0x2, 0xF in the next instruction cycle -> no inst_valid pulse in the first cycle; in the second cycle, inst_valid with opr = 0x4, opa = 0x1, operand = 0x2F.
REQ-041 halt held for 5 clocks starting at cycle 3 -> cycle, opr, and opa are frozen; after release, sampling resumes and inst_valid fires exactly once.
REQ-042 Reset asserted in WORD2 cycle 3 -> next cycle = 0, state WORD1, operand = 0; with the macro undefined, bus_in 0x4 then 0x1 gives a one-word inst_valid.
